bus_ctrl_mmio: RTL

Parametrised successor to the CPU-side bus controller. Decodes each CPU load/store into a one-hot slave select over NSLV memory/IO regions and drives registered address, data and write strobe to the selected slave. Waits for a slave acknowledge and returns read data plus a ready pulse to the CPU. Sits between top_cpu and the back-end peripheral unit (memory, LED, segment display).

---
 rtl/bus_ctrl_mmio.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bus_ctrl_mmio.sv
// CPU-side MMIO bus controller: decodes loads/stores onto NSLV one-hot slave regions
// and returns slave read data. Optional ack timeout enabled by defining BUS_TIMEOUT_EN.
module bus_ctrl_mmio #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 12,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_wdata,
  output logic [DW-1:0]        cpu_rdata,
  output logic                 cpu_ready,
  output logic                 cpu_err,
  output logic [NSLV-1:0]      bus_sel,
  output logic                 bus_we,
  output logic [AW-1:0]        bus_addr,
  output logic [DW-1:0]        bus_wdata,
  input  logic [NSLV*DW-1:0]   bus_rdata,
  input  logic [NSLV-1:0]      bus_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  if (NSLV < 1 || NSLV > 32 || (1 << SEL_W) < NSLV || TIMEOUT < 1) begin : g_param_check
    $error("bus_ctrl_mmio: illegal parameter combination");
  end

  state_t            state, state_d;
  logic [SEL_W-1:0]  idx, idx_q, idx_d;
  logic              idx_valid;
  logic              ack_hit;
  logic [NSLV-1:0]   sel_d;
  logic              we_d;
  logic [AW-1:0]     addr_d;
  logic [DW-1:0]     wdata_d;
  logic [DW-1:0]     rdata_d;
  logic              ready_d;
  logic              err_d;

  assign idx       = cpu_addr[SEL_LSB +: SEL_W];
  assign idx_valid = {1'b0, idx} < (SEL_W+1)'(NSLV);
  // bus_sel is one-hot on the latched index, so masking filters out stray acks
  assign ack_hit   = |(bus_ack & bus_sel);

`ifdef BUS_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CW-1:0] cnt, cnt_d;
`endif

  always_comb begin
    state_d = state;
    idx_d   = idx_q;
    sel_d   = bus_sel;
    we_d    = bus_we;
    addr_d  = bus_addr;
    wdata_d = bus_wdata;
    rdata_d = cpu_rdata;
    ready_d = 1'b0;
    err_d   = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt;
`endif
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (idx_valid) begin
            idx_d      = idx;
            sel_d      = '0;
            sel_d[idx] = 1'b1;
            we_d       = cpu_we;
            addr_d     = cpu_addr;
            wdata_d    = cpu_wdata;
`ifdef BUS_TIMEOUT_EN
            cnt_d      = '0;
`endif
            state_d    = ACCESS;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      ACCESS: begin
        if (ack_hit) begin
          if (!bus_we) rdata_d = bus_rdata[idx_q*DW +: DW];
          sel_d   = '0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT)) begin
          rdata_d = '0;
          sel_d   = '0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cpu_ready/cpu_err are registered on the transition into DONE, so they pulse during DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx_q     <= '0;
      bus_sel   <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_d;
      idx_q     <= idx_d;
      bus_sel   <= sel_d;
      bus_we    <= we_d;
      bus_addr  <= addr_d;
      bus_wdata <= wdata_d;
      cpu_rdata <= rdata_d;
      cpu_ready <= ready_d;
      cpu_err   <= err_d;
`ifdef BUS_TIMEOUT_EN
      cnt       <= cnt_d;
`endif
    end
  end

endmodule
